mul24_sched: RTL and testbench



---
 rtl/mul_pkg.sv | 33 +++
 rtl/booth_pp_gen.sv | 30 +++
 rtl/wallace_12x24.sv | 45 ++++
 rtl/mul24_sched.sv | 113 +++++++++++
 tb/tb_mul24_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types for the 24-bit Booth multiply scheduler: widths, Booth digit
// encoding, requester id and the stage-1 operand bundle.
package mul_pkg;

    localparam int DATA_W   = 24;
    localparam int NPP      = 12;
    localparam int S1_TAG_W = 4;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [S1_TAG_W-1:0] tag;
        src_t                src;
    } s1_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 12 rows, each already negated in
// full two's complement and shifted into place, so no correction row follows.
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    output logic [NPP-1:0][DATA_W-1:0] pp
);

    logic [DATA_W:0] bx;
    logic [DATA_W-1:0] neg_a;

    assign bx    = {b, 1'b0};
    assign neg_a = -a;

    always_comb begin
        pp = '0;
        for (int i = 0; i < NPP; i++) begin
            case (booth_decode(bx[2*i +: 3]))
                POS1:    pp[i] = a << (2*i);
                POS2:    pp[i] = a << (2*i + 1);
                NEG1:    pp[i] = neg_a << (2*i);
                NEG2:    pp[i] = neg_a << (2*i + 1);
                default: pp[i] = '0;
            endcase
        end
    end

endmodule

// File: rtl/wallace_12x24.sv
// Carry-save reduction of 12 rows to a sum/carry pair, modulo 2^24.
// The carry output is left unaligned; the consumer adds it shifted left by one.
module wallace_12x24
    import mul_pkg::*;
(
    input  logic [NPP-1:0][DATA_W-1:0] pp,
    output logic [DATA_W-1:0]          sum,
    output logic [DATA_W-1:0]          carry
);

    function automatic logic [DATA_W-1:0] maj(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y,
                                              input logic [DATA_W-1:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic [DATA_W-1:0] l1 [8];
    logic [DATA_W-1:0] l2 [6];
    logic [DATA_W-1:0] l3 [4];
    logic [DATA_W-1:0] l4 [3];

    // Inner levels carry aligned rows; only the last compressor stays raw.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            l1[2*i]   = pp[3*i] ^ pp[3*i+1] ^ pp[3*i+2];
            l1[2*i+1] = maj(pp[3*i], pp[3*i+1], pp[3*i+2]) << 1;
        end
        for (int i = 0; i < 2; i++) begin
            l2[2*i]   = l1[3*i] ^ l1[3*i+1] ^ l1[3*i+2];
            l2[2*i+1] = maj(l1[3*i], l1[3*i+1], l1[3*i+2]) << 1;
        end
        l2[4] = l1[6];
        l2[5] = l1[7];
        for (int i = 0; i < 2; i++) begin
            l3[2*i]   = l2[3*i] ^ l2[3*i+1] ^ l2[3*i+2];
            l3[2*i+1] = maj(l2[3*i], l2[3*i+1], l2[3*i+2]) << 1;
        end
        l4[0] = l3[0] ^ l3[1] ^ l3[2];
        l4[1] = maj(l3[0], l3[1], l3[2]) << 1;
        l4[2] = l3[3];
        sum   = l4[0] ^ l4[1] ^ l4[2];
        carry = maj(l4[0], l4[1], l4[2]);
    end

endmodule

// File: rtl/mul24_sched.sv
// Two-requester round-robin front end on a shared 3-stage 24x24 Booth multiplier.
// Latency 3 cycles from handshake to resp_valid; stalls collapse bubbles upstream of resp_ready.
module mul24_sched #(
    parameter int DATA_W = 24,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_src,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              busy
);
    import mul_pkg::*;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic grant0, grant1, hs;
    src_t ptr;
    s1_t  s1_sel, s1_q;

    logic [NPP-1:0][DATA_W-1:0] pp;
    logic [DATA_W-1:0] tree_sum, tree_carry;
    logic [DATA_W-1:0] sum2, carry2;
    logic [TAG_W-1:0]  tag2;
    src_t              src2;

    // Ready looks at the other requester's valid; valid never looks at ready.
    assign grant0 = req0_valid & (!req1_valid | (ptr == SRC0));
    assign grant1 = req1_valid & (!req0_valid | (ptr == SRC1));

    assign adv3 = !v3 | resp_ready;
    assign adv2 = !v2 | adv3;
    assign adv1 = !v1 | adv2;

    assign req0_ready = grant0 & adv1;
    assign req1_ready = grant1 & adv1;
    assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign resp_valid = v3;
    assign busy       = v1 | v2 | v3;

    always_comb begin
        if (grant1) s1_sel = '{a: req1_a, b: req1_b, tag: req1_tag, src: SRC1};
        else        s1_sel = '{a: req0_a, b: req0_b, tag: req0_tag, src: SRC0};
    end

    booth_pp_gen u_pp (
        .a  (s1_q.a),
        .b  (s1_q.b),
        .pp (pp)
    );

    wallace_12x24 u_tree (
        .pp    (pp),
        .sum   (tree_sum),
        .carry (tree_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= SRC0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            s1_q      <= '0;
            sum2      <= '0;
            carry2    <= '0;
            tag2      <= '0;
            src2      <= SRC0;
            resp_data <= '0;
            resp_src  <= 1'b0;
            resp_tag  <= '0;
        end else begin
            // Pointer names the requester that lost the last completed handshake.
            if (hs) ptr <= grant0 ? SRC1 : SRC0;
            if (adv1) begin
                v1 <= hs;
                if (hs) s1_q <= s1_sel;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    sum2   <= tree_sum;
                    carry2 <= tree_carry;
                    tag2   <= s1_q.tag;
                    src2   <= s1_q.src;
                end
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    resp_data <= sum2 + (carry2 << 1);
                    resp_src  <= src2;
                    resp_tag  <= tag2;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul24_sched.sv
// Randomised and directed bench for mul24_sched against a plain-arithmetic model.
module tb_mul24_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [23:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        resp_valid, resp_ready, resp_src, busy;
    logic [23:0] resp_data;
    logic [3:0]  resp_tag;

    always #5 clk = ~clk;

    mul24_sched #(.DATA_W(24), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_src(resp_src),
        .resp_tag(resp_tag), .busy(busy)
    );

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic [3:0]  t;
    } rsp_t;

    rsp_t expq[$];
    rsp_t gotq[$];
    int   checks = 0;
    int   errors = 0;
    logic pref;
    logic last_hs0, last_hs1;

    function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = {24'b0, a} * {24'b0, b};
        return p[23:0];
    endfunction

    // One clock: sample handshakes before the edge, land on the next falling edge.
    task automatic step();
        #1;
        last_hs0 = req0_valid && req0_ready;
        last_hs1 = req1_valid && req1_ready;
        if (last_hs0) begin
            expq.push_back('{d: ref_mul(req0_a, req0_b), s: 1'b0, t: req0_tag});
            pref = 1'b1;
        end
        if (last_hs1) begin
            expq.push_back('{d: ref_mul(req1_a, req1_b), s: 1'b1, t: req1_tag});
            pref = 1'b0;
        end
        if (resp_valid && resp_ready)
            gotq.push_back('{d: resp_data, s: resp_src, t: resp_tag});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        while (gotq.size() < expq.size() && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (gotq.size() != expq.size()) begin
            errors++;
            $display("FAIL %s_drain responses got %0d expected %0d", nm, gotq.size(), expq.size());
        end
    endtask

    task automatic issue(input logic s, input logic [23:0] a, input logic [23:0] b, input logic [3:0] t);
        int n = 0;
        if (s) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = t; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = t; end
        do begin
            step();
            n++;
        end while (!(s ? last_hs1 : last_hs0) && n < 20);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (!(s ? last_hs1 : last_hs0)) begin
            errors++;
            $display("FAIL issue_timeout src %0d not accepted within %0d cycles", s, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_a = '0; req1_b = '0; req1_tag = '0;
        pref = 1'b0;
        #12;
        checks++;
        if ({resp_valid, busy, resp_src, resp_data, resp_tag} !== 31'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b busy=%b src=%b data=%h tag=%h expected all zero",
                     resp_valid, busy, resp_src, resp_data, resp_tag);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b%b expected 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        expq.delete(); gotq.delete();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 24'd3; req0_b = 24'd5; req0_tag = 4'd2;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_ready got %b%b expected 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (resp_valid !== (c == 3)) begin
                errors++;
                $display("FAIL basic_latency cycle N+%0d resp_valid got %b expected %b", c, resp_valid, c == 3);
            end
            if (c < 3) step();
        end
        checks++;
        if ({resp_data, resp_src, resp_tag} !== {24'h00000F, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL basic_result got data=%h src=%b tag=%h expected 00000f 0 2", resp_data, resp_src, resp_tag);
        end
        step();
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_idle got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_arith();
        logic [23:0] va[7], vb[7], ve[7], r1, r2;
        logic        vs[7];
        r1 = 24'($urandom);
        r2 = 24'($urandom);
        va = '{24'hFFFFF9, 24'h7FFFFF, 24'h001000, r1, r2, 24'hFFFFFF, 24'h123457};
        vb = '{24'h000006, 24'h000002, 24'h001000, 24'hAAAAAA, 24'h555555, 24'hFFFFFF, 24'h800000};
        ve = '{24'hFFFFD6, 24'hFFFFFE, 24'h000000, ref_mul(r1, 24'hAAAAAA), ref_mul(r2, 24'h555555),
               24'h000001, 24'h800000};
        vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            expq.delete(); gotq.delete();
            issue(vs[i], va[i], vb[i], 4'(i));
            drain("arith");
            checks++;
            if (gotq.size() == 0 || gotq[0] !== {ve[i], vs[i], 4'(i)}) begin
                errors++;
                $display("FAIL arith_%0d a=%h b=%h got %h expected %h", i, va[i], vb[i],
                         gotq.size() ? gotq[0] : rsp_t'(0), {ve[i], vs[i], 4'(i)});
            end
        end
    endtask

    task automatic test_alternate();
        expq.delete(); gotq.delete();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 24'($urandom); req0_b = 24'($urandom); req0_tag = 4'($urandom);
        req1_a = 24'($urandom); req1_b = 24'($urandom); req1_tag = 4'($urandom);
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== {!pref, pref}) begin
                errors++;
                $display("FAIL alt_grant cycle %0d got %b%b expected %b%b", c, req0_ready, req1_ready, !pref, pref);
            end
            step();
            if (last_hs0) begin req0_a = 24'($urandom); req0_b = 24'($urandom); req0_tag = 4'($urandom); end
            if (last_hs1) begin req1_a = 24'($urandom); req1_b = 24'($urandom); req1_tag = 4'($urandom); end
        end
        drain("alt");
        for (int i = 1; i < expq.size(); i++) begin
            checks++;
            if (expq[i].s === expq[i-1].s) begin
                errors++;
                $display("FAIL alt_order entry %0d src %b repeats", i, expq[i].s);
            end
        end
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (i >= gotq.size() || gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL alt_resp %0d got %h expected %h", i, i < gotq.size() ? gotq[i] : rsp_t'(0), expq[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [23:0] oa[4], ob[4];
        logic [3:0]  ot[4];
        int k = 0;
        expq.delete(); gotq.delete();
        for (int i = 0; i < 4; i++) begin
            oa[i] = 24'($urandom); ob[i] = 24'($urandom); ot[i] = 4'(i + 8);
        end
        resp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req0_valid = 1'b1; req0_a = oa[k]; req0_b = ob[k]; req0_tag = ot[k];
            #1;
            checks++;
            if (req0_ready !== (c < 3)) begin
                errors++;
                $display("FAIL stall_ready cycle %0d got %b expected %b", c, req0_ready, c < 3);
            end
            if (c >= 3) begin
                checks++;
                if ({resp_valid, resp_data, resp_src, resp_tag} !== {1'b1, ref_mul(oa[0], ob[0]), 1'b0, ot[0]}) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got v=%b data=%h tag=%h expected 1 %h %h",
                             c, resp_valid, resp_data, resp_tag, ref_mul(oa[0], ob[0]), ot[0]);
                end
            end
            step();
            if (last_hs0) k++;
        end
        resp_ready = 1'b1;
        req0_a = oa[k]; req0_b = ob[k]; req0_tag = ot[k];
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got %b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (gotq.size() != j) begin
                errors++;
                $display("FAIL stall_drain_rate after %0d cycles got %0d responses expected %0d", j, gotq.size(), j);
            end
            if (j < 4) step();
        end
        drain("stall");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= gotq.size() || gotq[i] !== {ref_mul(oa[i], ob[i]), 1'b0, ot[i]}) begin
                errors++;
                $display("FAIL stall_resp %0d got %h expected %h", i, i < gotq.size() ? gotq[i] : rsp_t'(0),
                         {ref_mul(oa[i], ob[i]), 1'b0, ot[i]});
            end
        end
    endtask

    task automatic test_ptr_req1_only();
        expq.delete(); gotq.delete();
        if (pref) issue(1'b1, 24'd1, 24'd1, 4'd0);
        for (int c = 0; c < 3; c++) begin
            req1_valid = 1'b1; req1_a = 24'($urandom); req1_b = 24'($urandom); req1_tag = 4'(c);
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                errors++;
                $display("FAIL ptr_req1_grant %0d got %b%b expected 01", c, req0_ready, req1_ready);
            end
            step();
        end
        req0_valid = 1'b1; req0_a = 24'd7; req0_b = 24'd9; req0_tag = 4'd5;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ptr_after_req1 got %b%b expected 10", req0_ready, req1_ready);
        end
        step();
        drain("ptr");
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (i >= gotq.size() || gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL ptr_resp %0d got %h expected %h", i, i < gotq.size() ? gotq[i] : rsp_t'(0), expq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic        pv, pr, ps;
        logic [23:0] pd;
        logic [3:0]  pt;
        logic        g0, g1;
        expq.delete(); gotq.delete();
        pv = 1'b0; pr = 1'b1; ps = 1'b0; pd = '0; pt = '0;
        last_hs0 = 1'b0; last_hs1 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!req0_valid || last_hs0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_a = 24'($urandom); req0_b = 24'($urandom); req0_tag = 4'($urandom);
            end
            if (!req1_valid || last_hs1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_a = 24'($urandom); req1_b = 24'($urandom); req1_tag = 4'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g0 = req0_valid && (!req1_valid || !pref);
            g1 = req1_valid && (!req0_valid || pref);
            checks++;
            if ((req0_ready && !g0) || (req1_ready && !g1)) begin
                errors++;
                $display("FAIL rand_grant cycle %0d got %b%b allowed %b%b", c, req0_ready, req1_ready, g0, g1);
            end
            checks++;
            if (busy !== (expq.size() > gotq.size())) begin
                errors++;
                $display("FAIL rand_busy cycle %0d got %b expected %b", c, busy, expq.size() > gotq.size());
            end
            if (pv && !pr) begin
                checks++;
                if ({resp_valid, resp_data, resp_src, resp_tag} !== {1'b1, pd, ps, pt}) begin
                    errors++;
                    $display("FAIL rand_hold cycle %0d got %b %h %b %h expected 1 %h %b %h",
                             c, resp_valid, resp_data, resp_src, resp_tag, pd, ps, pt);
                end
            end
            pv = resp_valid; pr = resp_ready; pd = resp_data; ps = resp_src; pt = resp_tag;
            step();
        end
        drain("rand");
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (i >= gotq.size() || gotq[i] !== expq[i]) begin
                errors++;
                $display("FAIL rand_resp %0d got %h expected %h", i, i < gotq.size() ? gotq[i] : rsp_t'(0), expq[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        expq.delete(); gotq.delete();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 24'h000011; req0_b = 24'h000022; req0_tag = 4'd1;
        step();
        req0_a = 24'h000033; req0_tag = 4'd2;
        step();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_async got v=%b busy=%b expected 0 0", resp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete(); gotq.delete();
        pref = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({resp_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d got v=%b busy=%b expected 0 0", c, resp_valid, busy);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_grant got %b%b expected 10", req0_ready, req1_ready);
        end
        step();
        drain("midreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_alternate();
        test_stall();
        test_ptr_req1_only();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
